fsm5_seq_gen: RTL and testbench

FSM5_SEQ_GEN -- requirements
Module: fsm5_seq_gen

---
 rtl/fsm5_seq_gen.sv | 123 ++++++++++++
 tb/tb_fsm5_seq_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fsm5_seq_gen.sv
// Serial frame generator: captures a pattern on START and shifts its active field out MSB first.
// Define SEQGEN_REPEAT_EN to add the repeat_req port and gap-separated continuous transmission.
module fsm5_seq_gen #(
  parameter int PAT_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
`ifdef SEQGEN_REPEAT_EN
  input  logic             repeat_req,
`endif
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state, state_d;
  logic [PAT_W-1:0] frame, frame_d;
  logic [PAT_W-1:0] shreg, shreg_d;
  logic [3:0]       cnt, cnt_d;
  logic [3:0]       len_m1, len_m1_d;
  logic             out_d;
  logic [3:0]       len_eff;
  logic [PAT_W-1:0] aligned;

  // Frame is left-aligned so the active field's MSB always sits at the top bit.
  always_comb begin
    if ((len == 4'd0) || (len > 4'(PAT_W))) len_eff = 4'(PAT_W);
    else                                    len_eff = len;
    aligned = pattern << (4'(PAT_W) - len_eff);
  end

  always_comb begin
    state_d  = state;
    frame_d  = frame;
    shreg_d  = shreg;
    cnt_d    = cnt;
    len_m1_d = len_m1;
    out_d    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          frame_d  = aligned;
          shreg_d  = aligned;
          len_m1_d = len_eff - 4'd1;
          cnt_d    = len_eff - 4'd1;
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        out_d   = shreg[PAT_W-1];
        shreg_d = shreg << 1;
      end
      S_SHIFT: begin
        if (cnt == 4'd0) begin
`ifdef SEQGEN_REPEAT_EN
          if (repeat_req) begin
            state_d = S_GAP;
            cnt_d   = 4'(GAP_CYC - 1);
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          out_d   = shreg[PAT_W-1];
          shreg_d = shreg << 1;
          cnt_d   = cnt - 4'd1;
        end
      end
      // The counter is reused for gap timing, then reloaded for the next pass.
      S_GAP: begin
        if (cnt == 4'd0) begin
          state_d = S_SHIFT;
          out_d   = frame[PAT_W-1];
          shreg_d = frame << 1;
          cnt_d   = len_m1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      frame  <= '0;
      shreg  <= '0;
      cnt    <= '0;
      len_m1 <= '0;
      out    <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      frame  <= frame_d;
      shreg  <= shreg_d;
      cnt    <= cnt_d;
      len_m1 <= len_m1_d;
      out    <= out_d;
      valid  <= (state_d == S_SHIFT);
      busy   <= (state_d != S_IDLE);
      done   <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_fsm5_seq_gen.sv
// Directed bench for fsm5_seq_gen: expected serial bits are queued at START and popped per VALID cycle.
module tb_fsm5_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
`ifdef SEQGEN_REPEAT_EN
  logic       repeat_req;
`endif
  logic       out, valid, busy, done;

  int n_assert = 0;
  int n_fail   = 0;
  logic exp_q[$];

  fsm5_seq_gen #(.PAT_W(8), .GAP_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len),
`ifdef SEQGEN_REPEAT_EN
    .repeat_req(repeat_req),
`endif
    .out(out), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_bits(input logic [7:0] pat, input int l);
    logic [7:0] p;
    p = pat;
    for (int i = l - 1; i >= 0; i--) exp_q.push_back(p[i]);
  endtask

  // Every VALID cycle consumes one queued bit.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      chk("bit_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) chk("out_bit", 16'(out), 16'(exp_q.pop_front()));
    end
  end

  task automatic run_frame(input logic [7:0] pat, input logic [3:0] l_in, input int l_exp,
                           input bit poke);
    chk("idle_busy", 16'(busy), 16'd0);
    pattern = pat;
    len     = l_in;
    start   = 1'b1;
    push_bits(pat, l_exp);
    @(posedge clk); #1;
    start   = 1'b0;
    pattern = ~pat;
    len     = 4'd1;
    chk("load_flags", {13'd0, out, valid, busy}, 16'b001);
    for (int i = 0; i < l_exp; i++) begin
      @(posedge clk); #1;
      chk("shift_valid", {14'd0, valid, done}, 16'b10);
      start = (poke && i == 2) ? 1'b1 : 1'b0;
    end
    @(posedge clk); #1;
    chk("done_flags", {12'd0, out, valid, busy, done}, 16'b0011);
    if (poke) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_done_idle", {14'd0, busy, done}, 16'b00);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
    chk("no_second_frame", {14'd0, busy, valid}, 16'b00);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    len     = 4'd0;
`ifdef SEQGEN_REPEAT_EN
    repeat_req = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {12'd0, out, valid, busy, done}, 16'b0000);
    start = 1'b1;
    @(posedge clk); #1;
    chk("start_in_reset", 16'(busy), 16'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(8'hB4, 4'd8,  8, 1'b0);
    run_frame(8'h05, 4'd3,  3, 1'b0);
    run_frame(8'hFF, 4'd0,  8, 1'b0);
    run_frame(8'hA5, 4'd12, 8, 1'b0);
    run_frame(8'h3C, 4'd5,  5, 1'b1);
    run_frame(8'h01, 4'd1,  1, 1'b0);

    // Asynchronous reset after the third bit of a frame.
    pattern = 8'hE7;
    len     = 4'd8;
    start   = 1'b1;
    push_bits(8'hE7, 8);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {12'd0, out, valid, busy, done}, 16'b0000);
    chk("bits_before_reset", 16'(exp_q.size()), 16'd5);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no_resume", {14'd0, busy, valid}, 16'b00);
    run_frame(8'h96, 4'd8, 8, 1'b0);

`ifdef SEQGEN_REPEAT_EN
    pattern    = 8'h0F;
    len        = 4'd4;
    repeat_req = 1'b1;
    start      = 1'b1;
    push_bits(8'h0F, 4);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rpt_valid1", 16'(valid), 16'd1);
    end
    push_bits(8'h0F, 4);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rpt_gap", {12'd0, out, valid, busy, done}, 16'b0010);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rpt_valid2", 16'(valid), 16'd1);
      repeat_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("rpt_done", {14'd0, valid, done}, 16'b01);
    @(posedge clk); #1;
    chk("rpt_idle", 16'(busy), 16'd0);
    chk("rpt_drained", 16'(exp_q.size()), 16'd0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
